// File: rtl/pci_arb_pkg.sv
// Shared types and helpers for the PCI bus arbiter: FSM state encoding,
// default sizing, and one-hot to index conversion.
package pci_arb_pkg;

  localparam int DEF_NUM_MASTERS = 4;
  localparam int DEF_GNT_TIMEOUT = 16;
  localparam int MAX_MASTERS     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    TURN  = 2'd3
  } arb_state_e;

  // Index of the set bit; for a zero vector the result is 0.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pci_rr_picker.sv
// Combinational round-robin picker: the search starts at last_i+1 and wraps,
// so the previous owner has the lowest priority.
module pci_rr_picker
  import pci_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS
) (
  input  logic [NUM_MASTERS-1:0]         req_i,
  input  logic [$clog2(NUM_MASTERS)-1:0] last_i,
  output logic [$clog2(NUM_MASTERS)-1:0] win_o,
  output logic                           vld_o
);

  localparam int IW = $clog2(NUM_MASTERS);

  logic [MAX_MASTERS-1:0] oh;
  logic [IW-1:0]          c;

  // Walk from farthest to nearest; the last hit is the closest after last_i.
  always_comb begin
    oh = '0;
    c  = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      c = IW'((int'(last_i) + k) % NUM_MASTERS);
      if (req_i[c]) oh = MAX_MASTERS'(1) << c;
    end
  end

  assign win_o = IW'(onehot_to_idx(oh));
  assign vld_o = |req_i;

endmodule

// File: rtl/pci_arbiter.sv
// PCI central arbiter: round-robin grant, hidden arbitration, GNT timeout.
// Optional bus parking on the last owner when PCI_ARB_PARK_EN is defined.
module pci_arbiter
  import pci_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT
) (
  input  logic                           CLK,
  input  logic                           REST,
  input  logic [NUM_MASTERS-1:0]         REQ,
  input  logic                           FRAME,
  input  logic                           IRDY,
  output logic [NUM_MASTERS-1:0]         GNT,
  output logic [$clog2(NUM_MASTERS)-1:0] OWNER,
  output logic                           BUS_BUSY
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int TW = $clog2(GNT_TIMEOUT) + 1;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;

  logic [NUM_MASTERS-1:0] reqv, own_oh, win_oh;
  logic [IW-1:0]          win;
  logic                   win_vld, own_req, others, bus_idle, tmo;

  assign reqv     = ~REQ;
  assign own_oh   = NUM_MASTERS'(1) << owner_q;
  assign win_oh   = NUM_MASTERS'(1) << win;
  assign own_req  = reqv[owner_q];
  assign others   = |(reqv & ~own_oh);
  assign bus_idle = FRAME & IRDY;
  assign tmo      = (tcnt_q >= TW'(GNT_TIMEOUT - 1));

  pci_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req_i (reqv),
    .last_i(owner_q),
    .win_o (win),
    .vld_o (win_vld)
  );

`ifdef PCI_ARB_PARK_EN
  // Set when a parked grant was dropped to hand the bus to a preselected owner.
  logic pre_q, pre_d;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    tcnt_d  = tcnt_q;
`ifdef PCI_ARB_PARK_EN
    pre_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef PCI_ARB_PARK_EN
        gnt_d = ~own_oh;
        if (pre_q && own_req) begin
          state_d = GRANT;
          tcnt_d  = '0;
        end else if (win_vld && (gnt_q != '1) && (win != owner_q)) begin
          state_d = TURN;
          gnt_d   = '1;
          owner_d = win;
          pre_d   = 1'b1;
        end else if (win_vld) begin
          state_d = GRANT;
          gnt_d   = ~win_oh;
          owner_d = win;
          tcnt_d  = '0;
        end
`else
        gnt_d = '1;
        if (win_vld) begin
          state_d = GRANT;
          gnt_d   = ~win_oh;
          owner_d = win;
          tcnt_d  = '0;
        end
`endif
      end
      GRANT: begin
        if (tcnt_q != '1) tcnt_d = tcnt_q + TW'(1);
        if (!FRAME) begin
          state_d = BUSY;
        end else if (!own_req || tmo) begin
          state_d = TURN;
          gnt_d   = '1;
        end
      end
      BUSY: begin
        // Hidden arbitration: drop the owner's grant once anyone else waits.
        if (others) gnt_d = '1;
        if (bus_idle) begin
          state_d = TURN;
          gnt_d   = '1;
        end
      end
      TURN: begin
        state_d = IDLE;
`ifdef PCI_ARB_PARK_EN
        gnt_d   = ~own_oh;
`else
        gnt_d   = '1;
`endif
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (REST) begin
      state_q <= IDLE;
      gnt_q   <= '1;
      owner_q <= IW'(NUM_MASTERS - 1);
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      tcnt_q  <= tcnt_d;
    end
  end

`ifdef PCI_ARB_PARK_EN
  always_ff @(posedge CLK) begin
    if (REST) pre_q <= 1'b0;
    else      pre_q <= pre_d;
  end
`endif

  assign GNT      = gnt_q;
  assign OWNER    = owner_q;
  assign BUS_BUSY = (state_q == BUSY);

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed bench for pci_arbiter (4 masters, 16-clock grant timeout).
module tb_pci_arbiter;

  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         REST = 1'b1;
  logic [N-1:0] REQ = '1;
  logic         FRAME = 1'b1;
  logic         IRDY = 1'b1;
  logic [N-1:0] GNT;
  logic [1:0]   OWNER;
  logic         BUS_BUSY;

  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  pci_arbiter #(.NUM_MASTERS(N), .GNT_TIMEOUT(16)) dut (
    .CLK(CLK), .REST(REST), .REQ(REQ), .FRAME(FRAME), .IRDY(IRDY),
    .GNT(GNT), .OWNER(OWNER), .BUS_BUSY(BUS_BUSY)
  );

  typedef struct {
    logic [3:0] req;
    logic       frame;
    logic       irdy;
    logic [3:0] gnt;
    logic [1:0] own;
    logic       busy;
  } vec_t;

  vec_t tv[22];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] eg, input logic [1:0] eo, input logic eb);
    nvec++;
    if (GNT !== eg || OWNER !== eo || BUS_BUSY !== eb) begin
      nerr++;
      $display("FAIL %s: got gnt=%b owner=%0d busy=%b, want gnt=%b owner=%0d busy=%b",
               nm, GNT, OWNER, BUS_BUSY, eg, eo, eb);
    end
  endtask

  task automatic do_reset();
    REST = 1'b1; REQ = '1; FRAME = 1'b1; IRDY = 1'b1;
    step(); step();
    chk("reset", 4'b1111, 2'd3, 1'b0);
    REST = 1'b0;
  endtask

  initial begin
    logic [3:0] eg;
    logic [1:0] eo;

`ifdef PCI_ARB_PARK_EN
    do_reset();
    step();             chk("park_idle",   4'b0111, 2'd3, 1'b0);
    REQ = 4'b1110; step(); chk("park_turn", 4'b1111, 2'd0, 1'b0);
    step();             chk("park_new",    4'b1110, 2'd0, 1'b0);
    step();             chk("park_grant",  4'b1110, 2'd0, 1'b0);
    FRAME = 1'b0; step(); chk("park_busy", 4'b1110, 2'd0, 1'b1);
    FRAME = 1'b1; REQ = 4'b1111; step(); chk("park_turn2", 4'b1111, 2'd0, 1'b0);
    step();             chk("park_reidle", 4'b1110, 2'd0, 1'b0);
    REQ = 4'b1110; step(); chk("park_self", 4'b1110, 2'd0, 1'b0);
    FRAME = 1'b0; step(); chk("park_self_busy", 4'b1110, 2'd0, 1'b1);
    FRAME = 1'b1;
`else
    //           req      f     i     gnt      own   busy
    tv[0]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd3, 1'b0};
    tv[1]  = '{4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0};
    tv[2]  = '{4'b1110, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0};
    tv[3]  = '{4'b1110, 1'b0, 1'b1, 4'b1110, 2'd0, 1'b1};
    tv[4]  = '{4'b1110, 1'b0, 1'b0, 4'b1110, 2'd0, 1'b1};
    tv[5]  = '{4'b1111, 1'b1, 1'b0, 4'b1110, 2'd0, 1'b1};
    tv[6]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0};
    tv[7]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0};
    tv[8]  = '{4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0};
    tv[9]  = '{4'b1101, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b1};
    tv[10] = '{4'b0101, 1'b0, 1'b0, 4'b1111, 2'd1, 1'b1};
    tv[11] = '{4'b0101, 1'b1, 1'b0, 4'b1111, 2'd1, 1'b1};
    tv[12] = '{4'b0111, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0};
    tv[13] = '{4'b0111, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0};
    tv[14] = '{4'b0111, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0};
    tv[15] = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd3, 1'b0};
    tv[16] = '{4'b1111, 1'b1, 1'b1, 4'b1111, 2'd3, 1'b0};
    tv[17] = '{4'b0000, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0};
    tv[18] = '{4'b0000, 1'b0, 1'b1, 4'b1110, 2'd0, 1'b1};
    tv[19] = '{4'b0000, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0};
    tv[20] = '{4'b0000, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0};
    tv[21] = '{4'b0000, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0};

    do_reset();
    for (int i = 0; i < 22; i++) begin
      REQ = tv[i].req; FRAME = tv[i].frame; IRDY = tv[i].irdy;
      step();
      chk($sformatf("vec%0d", i), tv[i].gnt, tv[i].own, tv[i].busy);
    end

    // Reset in the middle of a transaction wins over FRAME/IRDY.
    FRAME = 1'b0; step(); chk("mid_busy", 4'b1101, 2'd1, 1'b1);
    REST = 1'b1; IRDY = 1'b0; step(); chk("mid_reset", 4'b1111, 2'd3, 1'b0);
    REST = 1'b0; FRAME = 1'b1; IRDY = 1'b1; REQ = '1;

    // All masters requesting: three full round-robin rounds.
    do_reset();
    REQ = 4'b0000;
    step();
    for (int r = 0; r < 12; r++) begin
      eo = 2'(r % 4);
      eg = ~(4'b0001 << eo);
      chk($sformatf("rr_gnt%0d", r), eg, eo, 1'b0);
      FRAME = 1'b0; step(); chk($sformatf("rr_busy%0d", r), 4'b1111 & eg, eo, 1'b1);
      FRAME = 1'b1; step(); chk($sformatf("rr_turn%0d", r), 4'b1111, eo, 1'b0);
      step();               chk($sformatf("rr_idle%0d", r), 4'b1111, eo, 1'b0);
      step();
    end

    // Master 2 granted but never drives FRAME: released after 16 clocks.
    do_reset();
    REQ = 4'b1011; step(); chk("to_gnt", 4'b1011, 2'd2, 1'b0);
    REQ = 4'b1010;
    for (int i = 1; i < 16; i++) begin
      step(); chk($sformatf("to_hold%0d", i), 4'b1011, 2'd2, 1'b0);
    end
    step(); chk("to_rel",  4'b1111, 2'd2, 1'b0);
    step(); chk("to_idle", 4'b1111, 2'd2, 1'b0);
    step(); chk("to_next", 4'b1110, 2'd0, 1'b0);
    REQ = '1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
